// File: rtl/imem_dmem_arbiter.sv
// Shares one synchronous-read memory port between instruction fetch and data access.
// Data wins ties unless fetch has been starved; responses return one cycle after acceptance.
module imem_dmem_arbiter #(
    parameter int ADDR_WIDTH   = 12,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    f_req_valid,
    output logic                    f_req_ready,
    input  logic [ADDR_WIDTH-1:0]   f_addr,
    input  logic                    d_req_valid,
    output logic                    d_req_ready,
    input  logic [ADDR_WIDTH-1:0]   d_addr,
    input  logic [DATA_WIDTH-1:0]   d_wdata,
    input  logic [DATA_WIDTH/8-1:0] d_wbe,
    output logic                    f_resp_valid,
    output logic [DATA_WIDTH-1:0]   f_resp_rdata,
    output logic                    d_resp_valid,
    output logic [DATA_WIDTH-1:0]   d_resp_rdata,
    output logic                    mem_en,
    output logic [DATA_WIDTH/8-1:0] mem_we,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    output logic [DATA_WIDTH-1:0]   mem_din,
    input  logic [DATA_WIDTH-1:0]   mem_dout
);

    localparam int CNT_WIDTH = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(STARVE_LIMIT);

    logic [CNT_WIDTH-1:0] starveCnt_q, starveCnt_d;
    logic                 respPending_q, respPending_d;
    logic                 respOwner_q, respOwner_d;
    logic                 fetchStarved;
    logic                 grantF;
    logic                 grantD;

    // With STARVE_LIMIT=0 the counter is pinned at its limit, so fetch always wins ties.
    always_comb begin
        fetchStarved = (starveCnt_q == CNT_LIMIT);
        grantD       = rst && d_req_valid && !(f_req_valid && fetchStarved);
        grantF       = rst && f_req_valid && !grantD;
    end

    always_comb begin
        starveCnt_d   = '0;
        respPending_d = grantF || grantD;
        respOwner_d   = grantD;
        if (f_req_valid && !grantF) begin
            starveCnt_d = fetchStarved ? starveCnt_q : starveCnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starveCnt_q   <= '0;
            respPending_q <= 1'b0;
            respOwner_q   <= 1'b0;
        end else begin
            starveCnt_q   <= starveCnt_d;
            respPending_q <= respPending_d;
            respOwner_q   <= respOwner_d;
        end
    end

    assign f_req_ready  = grantF;
    assign d_req_ready  = grantD;

    assign mem_en       = grantF || grantD;
    assign mem_addr     = grantD ? d_addr : f_addr;
    assign mem_we       = grantD ? d_wbe : '0;
    assign mem_din      = d_wdata;

    // Read data is not registered here; the memory already delays it by one cycle.
    assign f_resp_valid = rst && respPending_q && !respOwner_q;
    assign d_resp_valid = rst && respPending_q && respOwner_q;
    assign f_resp_rdata = mem_dout;
    assign d_resp_rdata = mem_dout;

endmodule

// File: tb/tb_imem_dmem_arbiter.sv
// Directed bench for imem_dmem_arbiter: default instance plus a STARVE_LIMIT=0 instance,
// each backed by a byte-writable synchronous-read memory model.
module tb_imem_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        fValid = 1'b0;
    logic [11:0] fAddr = '0;
    logic        dValid = 1'b0;
    logic [11:0] dAddr = '0;
    logic [31:0] dWdata = '0;
    logic [3:0]  dWbe = '0;

    logic        fReadyA, dReadyA, fRespValidA, dRespValidA, memEnA;
    logic [31:0] fRdataA, dRdataA, memDinA, memDoutA;
    logic [3:0]  memWeA;
    logic [11:0] memAddrA;

    logic        fReadyB, dReadyB, fRespValidB, dRespValidB, memEnB;
    logic [31:0] fRdataB, dRdataB, memDinB, memDoutB;
    logic [3:0]  memWeB;
    logic [11:0] memAddrB;

    logic [31:0] memA [0:4095];
    logic [31:0] memB [0:4095];
    logic        memLoaded = 1'b0;

    int testsRun = 0;
    int testsFailed = 0;

    always #5 clk = ~clk;

    imem_dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .STARVE_LIMIT(4)) dutA (
        .clk(clk), .rst(rst),
        .f_req_valid(fValid), .f_req_ready(fReadyA), .f_addr(fAddr),
        .d_req_valid(dValid), .d_req_ready(dReadyA), .d_addr(dAddr),
        .d_wdata(dWdata), .d_wbe(dWbe),
        .f_resp_valid(fRespValidA), .f_resp_rdata(fRdataA),
        .d_resp_valid(dRespValidA), .d_resp_rdata(dRdataA),
        .mem_en(memEnA), .mem_we(memWeA), .mem_addr(memAddrA),
        .mem_din(memDinA), .mem_dout(memDoutA)
    );

    imem_dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .STARVE_LIMIT(0)) dutB (
        .clk(clk), .rst(rst),
        .f_req_valid(fValid), .f_req_ready(fReadyB), .f_addr(fAddr),
        .d_req_valid(dValid), .d_req_ready(dReadyB), .d_addr(dAddr),
        .d_wdata(dWdata), .d_wbe(dWbe),
        .f_resp_valid(fRespValidB), .f_resp_rdata(fRdataB),
        .d_resp_valid(dRespValidB), .d_resp_rdata(dRdataB),
        .mem_en(memEnB), .mem_we(memWeB), .mem_addr(memAddrB),
        .mem_din(memDinB), .mem_dout(memDoutB)
    );

    function automatic logic [31:0] initWord(input int addr);
        case (addr)
            16:      return 32'hDEADBEEF;
            32:      return 32'hAAAAAAAA;
            48:      return 32'h30303030;
            64:      return 32'h40404040;
            default: return 32'h0;
        endcase
    endfunction

    // Memory models load their contents on the first edge, which falls inside reset.
    always @(posedge clk) begin
        if (!memLoaded) begin
            for (int i = 0; i < 4096; i++) begin
                memA[i] <= initWord(i);
                memB[i] <= initWord(i);
            end
            memLoaded <= 1'b1;
        end else begin
            if (memEnA) begin
                memDoutA <= memA[memAddrA];
                for (int b = 0; b < 4; b++)
                    if (memWeA[b]) memA[memAddrA][8*b +: 8] <= memDinA[8*b +: 8];
            end
            if (memEnB) begin
                memDoutB <= memB[memAddrB];
                for (int b = 0; b < 4; b++)
                    if (memWeB[b]) memB[memAddrB][8*b +: 8] <= memDinB[8*b +: 8];
            end
        end
    end

    task automatic applyStimulus(input logic fv, input logic [11:0] fa, input logic dv,
                                 input logic [11:0] da, input logic [31:0] wd,
                                 input logic [3:0] wbe);
        fValid = fv;
        fAddr  = fa;
        dValid = dv;
        dAddr  = da;
        dWdata = wd;
        dWbe   = wbe;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, observed, expected, $time);
        end
    endtask

    task automatic nextCycle;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic prevF;

        // Reset state with both requesters asserting, including a write.
        applyStimulus(1'b1, 12'h010, 1'b1, 12'h020, 32'hFFFFFFFF, 4'hF);
        #12;
        checkOutput("rst_f_ready", fReadyA, 0);
        checkOutput("rst_d_ready", dReadyA, 0);
        checkOutput("rst_mem_en", memEnA, 0);
        checkOutput("rst_mem_we", memWeA, 0);
        checkOutput("rst_f_resp", fRespValidA, 0);
        checkOutput("rst_d_resp", dRespValidA, 0);
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1 rst = 1'b1;

        // Single fetch read.
        nextCycle();
        applyStimulus(1'b1, 12'h010, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t1_f_ready", fReadyA, 1);
        checkOutput("t1_d_ready", dReadyA, 0);
        checkOutput("t1_mem_en", memEnA, 1);
        checkOutput("t1_mem_we", memWeA, 0);
        checkOutput("t1_mem_addr", memAddrA, 32'h010);
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t1_f_resp", fRespValidA, 1);
        checkOutput("t1_f_rdata", fRdataA, 32'hDEADBEEF);
        checkOutput("t1_d_resp", dRespValidA, 0);
        checkOutput("t1_idle_mem_en", memEnA, 0);

        // Partial write then read-back.
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b1, 12'h020, 32'h12345678, 4'b0011);
        #1;
        checkOutput("t2_d_ready", dReadyA, 1);
        checkOutput("t2_mem_we", memWeA, 4'b0011);
        checkOutput("t2_mem_addr", memAddrA, 32'h020);
        checkOutput("t2_mem_din", memDinA, 32'h12345678);
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b1, 12'h020, 32'h0, 4'h0);
        #1;
        checkOutput("t2_wr_resp", dRespValidA, 1);
        checkOutput("t2_wr_f_resp", fRespValidA, 0);
        checkOutput("t2_rd_mem_we", memWeA, 0);
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t2_rd_resp", dRespValidA, 1);
        checkOutput("t2_rd_rdata", dRdataA, 32'hAAAA5678);

        // Both valid for 20 cycles: D,D,D,D,F repeating.
        prevF = 1'b0;
        for (int i = 0; i < 20; i++) begin
            nextCycle();
            applyStimulus(1'b1, 12'h010, 1'b1, 12'h020, 32'h0, 4'h0);
            #1;
            checkOutput($sformatf("t3_f_ready_%0d", i), fReadyA, (i % 5 == 4));
            checkOutput($sformatf("t3_d_ready_%0d", i), dReadyA, (i % 5 != 4));
            if (i > 0) begin
                checkOutput($sformatf("t3_f_resp_%0d", i), fRespValidA, prevF);
                checkOutput($sformatf("t3_d_resp_%0d", i), dRespValidA, !prevF);
                checkOutput($sformatf("t3_rdata_%0d", i), fRdataA,
                            prevF ? 32'hDEADBEEF : 32'hAAAA5678);
            end
            prevF = (i % 5 == 4);
        end
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t3_last_f_resp", fRespValidA, 1);
        checkOutput("t3_last_rdata", fRdataA, 32'hDEADBEEF);

        // Alternating single requests, no bubbles.
        nextCycle();
        applyStimulus(1'b1, 12'h010, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t4_c0_f_ready", fReadyA, 1);
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b1, 12'h020, 32'h0, 4'h0);
        #1;
        checkOutput("t4_c1_d_ready", dReadyA, 1);
        checkOutput("t4_c1_f_resp", fRespValidA, 1);
        checkOutput("t4_c1_rdata", fRdataA, 32'hDEADBEEF);
        nextCycle();
        applyStimulus(1'b1, 12'h030, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t4_c2_f_ready", fReadyA, 1);
        checkOutput("t4_c2_d_resp", dRespValidA, 1);
        checkOutput("t4_c2_rdata", dRdataA, 32'hAAAA5678);
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b1, 12'h040, 32'h0, 4'h0);
        #1;
        checkOutput("t4_c3_d_ready", dReadyA, 1);
        checkOutput("t4_c3_f_resp", fRespValidA, 1);
        checkOutput("t4_c3_rdata", fRdataA, 32'h30303030);
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t4_c4_d_resp", dRespValidA, 1);
        checkOutput("t4_c4_f_resp", fRespValidA, 0);
        checkOutput("t4_c4_rdata", dRdataA, 32'h40404040);

        // Fetch accepted after four data grants, then async reset drops its response.
        for (int i = 0; i < 5; i++) begin
            nextCycle();
            applyStimulus(1'b1, 12'h010, 1'b1, 12'h100, 32'h5555AAAA, 4'hF);
            #1;
            checkOutput($sformatf("t5_pre_f_ready_%0d", i), fReadyA, (i == 4));
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        checkOutput("t5_rst_f_resp", fRespValidA, 0);
        checkOutput("t5_rst_d_resp", dRespValidA, 0);
        checkOutput("t5_rst_f_ready", fReadyA, 0);
        checkOutput("t5_rst_d_ready", dReadyA, 0);
        checkOutput("t5_rst_mem_en", memEnA, 0);
        checkOutput("t5_rst_mem_we", memWeA, 0);
        nextCycle();
        #1;
        checkOutput("t5_hold_f_resp", fRespValidA, 0);
        #2 rst = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("t5_post_d_ready_%0d", i), dReadyA, (i < 4));
            checkOutput($sformatf("t5_post_f_ready_%0d", i), fReadyA, (i == 4));
            checkOutput($sformatf("t5_post_f_resp_%0d", i), fRespValidA, 0);
            nextCycle();
            #1;
        end
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 4'h0);

        // STARVE_LIMIT=0 instance: fetch always wins ties.
        for (int i = 0; i < 3; i++) begin
            nextCycle();
            applyStimulus(1'b1, 12'h010, 1'b1, 12'h020, 32'h0, 4'h0);
            #1;
            checkOutput($sformatf("t6_f_ready_%0d", i), fReadyB, 1);
            checkOutput($sformatf("t6_d_ready_%0d", i), dReadyB, 0);
            if (i > 0) begin
                checkOutput($sformatf("t6_f_resp_%0d", i), fRespValidB, 1);
                checkOutput($sformatf("t6_f_rdata_%0d", i), fRdataB, 32'hDEADBEEF);
            end
        end
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b1, 12'h020, 32'h0, 4'h0);
        #1;
        checkOutput("t6_drop_d_ready", dReadyB, 1);
        checkOutput("t6_drop_f_ready", fReadyB, 0);
        checkOutput("t6_drop_mem_addr", memAddrB, 32'h020);
        nextCycle();
        applyStimulus(1'b0, 12'h0, 1'b0, 12'h0, 32'h0, 4'h0);
        #1;
        checkOutput("t6_d_resp", dRespValidB, 1);
        checkOutput("t6_d_rdata", dRdataB, 32'hAAAA5678);

        nextCycle();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
